// File: rtl/elevator_scheduler.sv
// elevator_scheduler: SCAN-policy car scheduler with per-floor call latches,
// travel/door timers and a single-car position register.
`default_nettype none

module elevator_scheduler #(
  parameter int FLOORS        = 8,
  parameter int FLOOR_W       = 3,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  input  logic [FLOOR_W-1:0] req_floor,
  input  logic               req_hall,
  input  logic               req_up,
  output logic [FLOOR_W-1:0] cur_floor,
  output logic               direction,
  output logic               moving,
  output logic               door_open,
  output logic               arrived,
  output logic [FLOORS-1:0]  call_inside,
  output logic [FLOORS-1:0]  call_up,
  output logic [FLOORS-1:0]  call_down
);

  localparam int C_CNT_MAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int C_CNT_W   = (C_CNT_MAX > 1) ? $clog2(C_CNT_MAX) : 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MOVING = 2'd1, S_DOOR = 2'd2} state_t;

  state_t               r_state, w_state_n;
  logic [C_CNT_W-1:0]   r_cnt, w_cnt_n;
  logic [FLOOR_W-1:0]   w_floor_n, w_next_floor, w_door_floor;
  logic                 w_dir_n, w_arrive_n, w_door_enter;
  logic                 w_req_ok, w_suppress, w_ahead, w_behind, w_stop;
  logic [FLOORS-1:0]    w_all, w_clr, w_set_in, w_set_up, w_set_dn;

  function automatic logic any_above(input logic [FLOORS-1:0] v, input logic [FLOOR_W-1:0] f);
    any_above = 1'b0;
    for (int i = 0; i < FLOORS; i++)
      if (i > int'(f) && v[i]) any_above = 1'b1;
  endfunction

  function automatic logic any_below(input logic [FLOORS-1:0] v, input logic [FLOOR_W-1:0] f);
    any_below = 1'b0;
    for (int i = 0; i < FLOORS; i++)
      if (i < int'(f) && v[i]) any_below = 1'b1;
  endfunction

  assign w_all        = call_inside | call_up | call_down;
  assign w_next_floor = direction ? (cur_floor + FLOOR_W'(1)) : (cur_floor - FLOOR_W'(1));

  assign w_req_ok = req_valid && (32'(req_floor) < FLOORS)
                 && !(req_hall &&  req_up && req_floor == FLOOR_W'(FLOORS - 1))
                 && !(req_hall && !req_up && req_floor == '0);

  always_comb begin
    w_state_n    = r_state;
    w_cnt_n      = r_cnt;
    w_floor_n    = cur_floor;
    w_dir_n      = direction;
    w_arrive_n   = 1'b0;
    w_door_enter = 1'b0;
    w_door_floor = cur_floor;
    w_ahead      = 1'b0;
    w_behind     = 1'b0;
    w_stop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_all[cur_floor]) begin
          w_state_n    = S_DOOR;
          w_cnt_n      = C_CNT_W'(DOOR_CYCLES - 1);
          w_door_enter = 1'b1;
        end else if (direction ? any_above(w_all, cur_floor) : any_below(w_all, cur_floor)) begin
          w_state_n = S_MOVING;
          w_cnt_n   = C_CNT_W'(TRAVEL_CYCLES - 1);
        end else if (direction ? any_below(w_all, cur_floor) : any_above(w_all, cur_floor)) begin
          w_state_n = S_MOVING;
          w_dir_n   = ~direction;
          w_cnt_n   = C_CNT_W'(TRAVEL_CYCLES - 1);
        end
      end
      S_MOVING: begin
        if (r_cnt == '0) begin
          w_floor_n  = w_next_floor;
          w_arrive_n = 1'b1;
          w_ahead    = direction ? any_above(w_all, w_next_floor) : any_below(w_all, w_next_floor);
          w_behind   = direction ? any_below(w_all, w_next_floor) : any_above(w_all, w_next_floor);
          w_stop     = call_inside[w_next_floor] || !w_ahead
                    || (direction ? call_up[w_next_floor] : call_down[w_next_floor]);
          if (w_stop) begin
            w_state_n    = S_DOOR;
            w_cnt_n      = C_CNT_W'(DOOR_CYCLES - 1);
            w_door_enter = 1'b1;
            w_door_floor = w_next_floor;
            if (!w_ahead && w_behind) w_dir_n = ~direction;
          end else begin
            w_cnt_n = C_CNT_W'(TRAVEL_CYCLES - 1);
          end
        end else begin
          w_cnt_n = r_cnt - C_CNT_W'(1);
        end
      end
      S_DOOR: begin
        // A fresh call for the open floor holds the door instead of queueing.
        if (w_req_ok && req_floor == cur_floor) w_cnt_n = C_CNT_W'(DOOR_CYCLES - 1);
        else if (r_cnt == '0)                  w_state_n = S_IDLE;
        else                                   w_cnt_n = r_cnt - C_CNT_W'(1);
      end
      default: w_state_n = S_IDLE;
    endcase

    w_suppress = (r_state == S_DOOR && req_floor == cur_floor)
              || (w_door_enter && req_floor == w_door_floor);
    w_clr    = '0;
    w_set_in = '0;
    w_set_up = '0;
    w_set_dn = '0;
    if (w_door_enter) w_clr[w_door_floor] = 1'b1;
    if (w_req_ok && !w_suppress) begin
      if (!req_hall)   w_set_in[req_floor] = 1'b1;
      else if (req_up) w_set_up[req_floor] = 1'b1;
      else             w_set_dn[req_floor] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      cur_floor   <= '0;
      direction   <= 1'b1;
      arrived     <= 1'b0;
      call_inside <= '0;
      call_up     <= '0;
      call_down   <= '0;
    end else begin
      r_state     <= w_state_n;
      r_cnt       <= w_cnt_n;
      cur_floor   <= w_floor_n;
      direction   <= w_dir_n;
      arrived     <= w_arrive_n;
      call_inside <= (call_inside | w_set_in) & ~w_clr;
      call_up     <= (call_up     | w_set_up) & ~w_clr;
      call_down   <= (call_down   | w_set_dn) & ~w_clr;
    end
  end

  assign moving    = (r_state == S_MOVING);
  assign door_open = (r_state == S_DOOR);

endmodule

`default_nettype wire

// File: doc/elevator_scheduler.md
# elevator_scheduler

Parametrised elevator car scheduler for a configurable number of floors. It latches inside-car and hall (up/down) calls into per-floor request vectors and runs a SCAN-style policy: keep moving in the current direction while calls remain ahead, then reverse. It owns car position, travel timing and door timing. It sits between the input manager (which produces floor/source/direction call strobes) and the display/top level.

## Interface
- FLOORS, 8: number of floors (≥2); floors numbered 0..FLOORS-1
- FLOOR_W, 3: floor index width, must equal ceil(log2(FLOORS))
- TRAVEL_CYCLES, 4: clock cycles to move one floor (≥1)
- DOOR_CYCLES, 3: clock cycles door stays open (≥1)

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  call strobe, sampled each rising edge
- req_floor  in  FLOOR_W  floor of the call
- req_hall  in  1  1 = hall call (outside), 0 = inside-car call
- req_up  in  1  hall call direction: 1 up, 0 down (ignored when req_hall=0)
- cur_floor  out  FLOOR_W  current car floor
- direction  out  1  1 up, 0 down
- moving  out  1  high in MOVING state
- door_open  out  1  high in DOOR_OPEN state
- arrived  out  1  one-cycle pulse the cycle after cur_floor changes
- call_inside, call_up, call_down  out  FLOORS  pending request vectors, bit i = floor i

## Operation
- Reset (async, reset=0): state IDLE, cur_floor=0, direction=1, moving=0, door_open=0, arrived=0, all call vectors 0, counters 0.
- Request latch: on edge with req_valid=1, set call_inside[f] (req_hall=0), else call_up[f] (req_up=1) or call_down[f]. Dropped: f ≥ FLOORS; hall up at FLOORS-1; hall down at 0. Request for f==cur_floor while in DOOR_OPEN (or on the edge entering DOOR_OPEN at f): not latched, door counter reloads to DOOR_CYCLES-1.
- "Ahead" = any call bit (any vector) strictly above cur_floor when direction=1, strictly below when 0.
- IDLE:
  - any call bit at cur_floor → DOOR_OPEN, clear all three bits at cur_floor, door counter = DOOR_CYCLES-1.
  - else calls ahead → MOVING, direction unchanged.
  - else calls behind → MOVING, direction flipped.
  - else stay IDLE.
  - Travel counter loads TRAVEL_CYCLES-1 on entry to MOVING.
- MOVING: counter decrements each cycle. On the edge where counter==0, cur_floor ±1 per direction, arrived pulses next cycle, then evaluate the new floor f:
  - stop if call_inside[f], or hall call matching direction at f, or no calls ahead of f.
  - stop → DOOR_OPEN, clear all three bits at f. If no calls ahead of f, direction flips in the same edge only if calls exist behind.
  - no stop → counter reloads TRAVEL_CYCLES-1, continue.
- Car never moves below 0 or above FLOORS-1; at an end floor, "ahead" is empty by definition.
- DOOR_OPEN: counter decrements; on edge with counter==0 → IDLE.
- Simultaneous set and clear of the same bit on one edge: clear wins.
- Width: cur_floor arithmetic in FLOOR_W bits, no wrap possible given the end-floor rules.

## Timing
- Request visible on call_* one cycle after the sampling edge.
- IDLE decision: one cycle (one edge in IDLE with a pending call).
- Per floor: exactly TRAVEL_CYCLES cycles with moving=1.
- Door: exactly DOOR_CYCLES cycles with door_open=1, absent re-requests.
- moving and door_open are never both high.
- Reset asserted mid-move or mid-door: all outputs return to reset values immediately; no state survives.

## Test plan
- Reset: assert reset=0 mid-MOVING at floor 3 → cur_floor=0, direction=1, all outputs 0 asynchronously; release, no movement without calls.
- Single inside call (FLOORS=8, TRAVEL=4, DOOR=3): inside req floor 2 at edge 1 → call_inside[2]=1 after edge 1, MOVING after edge 2, cur_floor=1 after edge 6, =2 after edge 10, door_open high for cycles 10–12, call_inside[2]=0 after edge 10, IDLE after edge 13.
- SCAN order: car at 3 moving up, pending inside 5, hall-down 4, inside 1 → stops at 5, passes 4 (down call, not matching), reverses, stops at 4 then 1; all vectors 0 at end.
- Door extension: while door_open at floor 2, req inside floor 2 each door cycle → door_open stays high, call_inside[2] never set; stop → closes DOOR_CYCLES later.
- Dropped requests: hall up at floor 7, hall down at 0, floor index beyond FLOORS (with FLOORS=6) → no call bit set, car stays IDLE.
- Parameter sweep: FLOORS=2, TRAVEL=1, DOOR=1 and FLOORS=16 → floor 0↔top round trips with correct cycle counts and arrived pulses once per floor.
